// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller.
// Drives the A operand (probe) of an external combinational magnitude
// comparator and binary-searches, MSB first, for the comparator's hidden
// B operand. The result is the largest value v with v <= target.
// The flags {cmp_eq, cmp_gt, cmp_st} must be exactly one-hot in every
// TEST cycle; otherwise the search aborts with err set.
// Optional feature macro: SAR_EARLY_EXIT_EN. When it is defined, an
// exact match ends the search immediately.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_st
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TEST = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_BIT = ONE_VAL << (WIDTH - 1);

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] accum_reg;
  logic [WIDTH-1:0] probe_reg;
  logic [WIDTH-1:0] result_reg;
  logic             found_reg;
  logic             err_reg;

  logic             flags_ok;
  logic [WIDTH-1:0] accum_next;
  logic [IDX_W-1:0] idx_dec;
  logic [WIDTH-1:0] bit_mask;

  // Flag validity and the candidate accumulator for this TEST cycle
  always_comb begin
    flags_ok = 1'b0;
    case ({cmp_eq, cmp_gt, cmp_st})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
    // probe <= target means the trial bit belongs in the answer
    accum_next = (cmp_eq | cmp_st) ? probe_reg : accum_reg;
  end

  assign idx_dec = idx_reg - IDX_W'(1);

  // One-hot mask selecting the next bit to try (bit idx-1)
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign bit_mask[gi] = (idx_dec == IDX_W'(gi));
    end
  endgenerate

  // Search FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      accum_reg  <= '0;
      probe_reg  <= '0;
      result_reg <= '0;
      found_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_TEST;
            idx_reg   <= IDX_W'(WIDTH - 1);
            accum_reg <= '0;
            probe_reg <= MSB_BIT;
            found_reg <= 1'b0;
            err_reg   <= 1'b0;
          end
        end
        ST_TEST: begin
          if (!flags_ok) begin
            // Broken comparator answer: abort with what was settled so far
            err_reg    <= 1'b1;
            result_reg <= accum_reg;
            state_reg  <= ST_DONE;
          end
`ifdef SAR_EARLY_EXIT_EN
          else if (cmp_eq) begin
            // Exact hit: the remaining low bits of probe are already zero
            result_reg <= probe_reg;
            found_reg  <= 1'b1;
            state_reg  <= ST_DONE;
          end
`endif
          else begin
            accum_reg <= accum_next;
            if (cmp_eq) found_reg <= 1'b1;
            if (idx_reg == '0) begin
              result_reg <= accum_next;
              state_reg  <= ST_DONE;
            end else begin
              idx_reg   <= idx_dec;
              probe_reg <= accum_next | bit_mask;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == ST_TEST);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;
  assign found  = found_reg;
  assign err    = err_reg;
  assign probe  = probe_reg;

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed bench for sar_search (WIDTH=4) with a
// behavioural comparator against a target register. Expectations follow
// SAR_EARLY_EXIT_EN when the bench is compiled with it.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       found;
  logic       err;
  logic [3:0] probe;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       cmp_st;

  logic [3:0] target;
  logic       force_bad;

  int n_cmp;
  int n_bad;

  sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err),
    .probe  (probe),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_st (cmp_st)
  );

  // Behavioural comparator; force_bad drives an illegal gt+st pattern
  assign cmp_eq = force_bad ? 1'b0 : (probe == target);
  assign cmp_gt = force_bad ? 1'b1 : (probe > target);
  assign cmp_st = force_bad ? 1'b1 : (probe < target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start one search, check every probe, the TEST-edge count and outcome
  task automatic do_search(input string tag, input logic [3:0] tgt,
                           input logic [15:0] probes_exp, input int n_exp,
                           input logic [3:0] res_exp, input logic found_exp);
    int cycles;
    target = tgt;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 12) begin
      if (cycles < n_exp)
        check($sformatf("%s_probe%0d", tag, cycles), 32'(probe),
              32'(probes_exp[(15 - 4 * cycles) -: 4]));
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_test_edges"}, 32'(cycles), 32'(n_exp));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(res_exp));
    check({tag, "_found"}, 32'(found), 32'(found_exp));
    check({tag, "_err"}, 32'(err), 32'd0);
    $display("search %s target=%0d result=%0d found=%0d err=%0d edges=%0d",
             tag, tgt, result, found, err, cycles);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    target    = 4'd0;
    force_bad = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_probe", 32'(probe), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Main searches
    do_search("t11", 4'd11, {4'd8, 4'd12, 4'd10, 4'd11}, 4, 4'd11, 1'b1);
    do_search("t0",  4'd0,  {4'd8, 4'd4,  4'd2,  4'd1},  4, 4'd0,  1'b0);
    do_search("t15", 4'd15, {4'd8, 4'd12, 4'd14, 4'd15}, 4, 4'd15, 1'b1);
`ifdef SAR_EARLY_EXIT_EN
    do_search("t12", 4'd12, {4'd8, 4'd12, 4'd0,  4'd0},  2, 4'd12, 1'b1);
`else
    do_search("t12", 4'd12, {4'd8, 4'd12, 4'd14, 4'd13}, 4, 4'd12, 1'b1);
`endif
    do_search("t5",  4'd5,  {4'd8, 4'd4,  4'd6,  4'd5},  4, 4'd5,  1'b1);

    // Illegal flags on the second TEST cycle abort the search
    target = 4'd11;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_probe0", 32'(probe), 32'd8);
    @(posedge clk); #1;
    check("bad_probe1", 32'(probe), 32'd12);
    force_bad = 1'b1;
    @(posedge clk); #1;
    force_bad = 1'b0;
    check("bad_done", 32'(done), 32'd1);
    check("bad_err", 32'(err), 32'd1);
    check("bad_result", 32'(result), 32'd8);
    check("bad_busy", 32'(busy), 32'd0);
    $display("search bad_flags result=%0d err=%0d", result, err);
    @(posedge clk); #1;
    check("bad_done_pulse", 32'(done), 32'd0);

    // Reset during the third TEST cycle discards the search
    target = 4'd11;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_probe2", 32'(probe), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_result", 32'(result), 32'd0);
    check("mid_found", 32'(found), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_probe", 32'(probe), 32'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("mid_no_done", 32'(dones), 32'd0);
    $display("reset mid-search busy=%0d done=%0d probe=%0d", busy, done, probe);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_search("t3", 4'd3, {4'd8, 4'd4, 4'd2, 4'd3}, 4, 4'd3, 1'b1);

    // start held high: back-to-back searches with one IDLE gap
    target = 4'd6;
    start  = 1'b1;
    @(posedge clk); #1;
    check("b2b_busy0", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_result1", 32'(result), 32'd6);
    @(posedge clk); #1;
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_busy1", 32'(busy), 32'd1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_done_count", 32'(dones), 32'd1);
    start = 1'b0;
    $display("back-to-back result=%0d found=%0d", result, found);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_stop_busy", 32'(busy), 32'd0);
    check("b2b_stop_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that drives the A operand of a 4-bit-class magnitude comparator and reads back its Eq/Gt/St flags. It binary-searches for the comparator's hidden B operand, MSB first, one bit per clock. It is the initiator end of the comparator interface: the comparator answers, this block asks. It is used to recover a threshold or target code from any compare-only datapath.

## Interface
Parameters:
- WIDTH, 4, operand width; probe, result and search depth are WIDTH bits/steps.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a new search; sampled only in IDLE.
- busy  output  1  high while a search is in progress (TEST state).
- done  output  1  one-cycle pulse when result/found/err are valid.
- result  output  WIDTH  recovered target code; held until next completion.
- found  output  1  an exact match (cmp_eq) was observed during the search.
- err  output  1  flag set was not one-hot in some TEST cycle; search aborted.
- probe  output  WIDTH  registered operand driven to comparator A input.
- cmp_eq  input  1  comparator: probe == target.
- cmp_gt  input  1  comparator: probe > target.
- cmp_st  input  1  comparator: probe < target.

## Operation
- The comparator is combinational. Flags are sampled on the clock edge that ends each TEST cycle, against the probe registered during that cycle.
- States:
  - IDLE: busy=0, done=0. start=1 -> TEST; idx<=WIDTH-1, accum<=0, probe<=1<<(WIDTH-1), found<=0, err<=0.
  - TEST: flags are checked first. If flags are not exactly one-hot -> DONE with err<=1, result<=accum. Otherwise, when cmp_eq|cmp_st, bit idx of probe is kept (accum_next = probe), else accum_next = accum. cmp_eq sets found. If idx==0 -> DONE with result<=accum_next. Else idx<=idx-1 and probe<=accum_next | (1<<(idx-1)).
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Search semantics: result = largest value v with v <= target. For target = 0 the value 0 is never probed, so result=0 and found=0. That combination is the defined "zero" answer, not an error.
- start is ignored in TEST and DONE. It is not queued.
- probe holds its last value in IDLE/DONE. It changes only at search start or TEST edges.
- Arithmetic is unsigned. No value exceeds WIDTH bits, and no carries occur (OR-based bit setting).

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, result=0, found=0, err=0, probe=0. An in-flight search is discarded and no done pulse is issued. Release is synchronous to clk; start is first honoured on the first edge after release.
- start sampled high at edge k (IDLE): busy rises after edge k. TEST edges are k+1 .. k+WIDTH.
- Full-length search: done is high in the cycle after edge k+WIDTH. busy falls at edge k+WIDTH. The earliest next start is at edge k+WIDTH+2 (IDLE).
- The err abort exits at the offending TEST edge, so done follows one cycle later.
- Outputs result/found/err update at the same edge that enters DONE. They are stable while done=1.

## Configuration
- SAR_EARLY_EXIT_EN defined: cmp_eq in TEST with valid flags goes to DONE immediately, with result<=probe and found<=1. A target whose lowest set bit is bit i completes after WIDTH-i TEST edges.
- Undefined: all WIDTH TEST cycles always execute; latency is fixed; found accumulates and does not shorten the search.

## Test plan
Bench uses a behavioral comparator against a reg target, WIDTH=4.
- target=4'b1011, start pulse -> probes 8,12,10,11; result=11, found=1, err=0. done exactly 5 cycles after the start edge (early-exit off).
- target=0 -> probes 8,4,2,1; result=0, found=0. target=15 -> probes 8,12,14,15; result=15, found=1.
- SAR_EARLY_EXIT_EN, target=4'b1100 -> probes 8,12; done after 2 TEST edges, result=12, found=1. The same target without the macro takes 4 TEST edges, with result=12.
- Force cmp_gt=cmp_st=1 on the second TEST cycle -> done next cycle, err=1, result=8 (accum after the first step with target>=8).
- Assert rst_n low during the third TEST cycle -> all outputs 0 immediately and no done pulse. After release, a new start with target=4'b0011 -> result=3.
- Hold start high continuously -> searches run back-to-back with one IDLE cycle between the done pulse and the next busy; start pulses during busy/done produce no extra search.
